// File: rtl/dct_zigzag_quant_if.sv
// Coefficient-in / level-out stream bundle for dct_zigzag_quant.
// out_last exists only when ZZ_EOB_EN is defined.
interface dct_zigzag_quant_if;
    logic              in_valid;
    logic signed [9:0] in_data;
    logic              out_valid;
    logic signed [7:0] out_data;
`ifdef ZZ_EOB_EN
    logic              out_last;

    modport master (output in_valid, in_data, input out_valid, out_data, out_last);
    modport slave  (input in_valid, in_data, output out_valid, out_data, out_last);
`else
    modport master (output in_valid, in_data, input out_valid, out_data);
    modport slave  (input in_valid, in_data, output out_valid, out_data);
`endif
endinterface

// File: rtl/dct_zigzag_quant.sv
// Ping-pong 4x4 block buffer, position-dependent rounded quantizer, zigzag reorder.
// Optional end-of-block flag bus.out_last is enabled by defining ZZ_EOB_EN.
module dct_zigzag_quant #(
    parameter int BASE_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    dct_zigzag_quant_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    logic signed [9:0] mem [2][16];
    logic              wbank, rbank;
    logic [3:0]        wcnt, rcnt;
    logic [1:0]        full;
    state_t            state;

    logic              rd_valid;
    logic signed [9:0] rd_x;
    logic [2:0]        rd_shift;
`ifdef ZZ_EOB_EN
    logic              rd_last;
`endif

    function automatic logic [3:0] zz(input logic [3:0] i);
        case (i)
            4'd0:    zz = 4'd0;
            4'd1:    zz = 4'd1;
            4'd2:    zz = 4'd4;
            4'd3:    zz = 4'd8;
            4'd4:    zz = 4'd5;
            4'd5:    zz = 4'd2;
            4'd6:    zz = 4'd3;
            4'd7:    zz = 4'd6;
            4'd8:    zz = 4'd9;
            4'd9:    zz = 4'd12;
            4'd10:   zz = 4'd13;
            4'd11:   zz = 4'd10;
            4'd12:   zz = 4'd7;
            4'd13:   zz = 4'd11;
            4'd14:   zz = 4'd14;
            default: zz = 4'd15;
        endcase
    endfunction

    // Shift grows by one for every two steps of anti-diagonal distance r+c.
    function automatic logic [2:0] pos_shift(input logic [3:0] k);
        logic [2:0] diag;
        diag = {1'b0, k[3:2]} + {1'b0, k[1:0]};
        pos_shift = 3'(BASE_SHIFT) + {1'b0, diag[2:1]};
    endfunction

    logic [3:0] rd_idx;
    logic       rd_go;

    assign rd_idx = zz(rcnt);
    assign rd_go  = (state == RUN) || full[rbank];

    // NOTE: the coefficient store has no reset; the full flags alone decide
    // whether its contents are ever read, so clearing it would only cost area.
    always_ff @(posedge clk) begin
        if (!rst && bus.in_valid)
            mem[wbank][wcnt] <= bus.in_data;
    end

    // NOTE: every sequential assignment is non-blocking so all state in this
    // block updates from the same pre-edge values, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
            full     <= '0;
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_x     <= '0;
            rd_shift <= '0;
`ifdef ZZ_EOB_EN
            rd_last  <= 1'b0;
`endif
        end else begin
            if (bus.in_valid) begin
                wcnt <= wcnt + 4'd1;
                if (wcnt == 4'd15) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end
            end

            rd_valid <= rd_go;
`ifdef ZZ_EOB_EN
            rd_last  <= rd_go && (rcnt == 4'd15);
`endif
            if (rd_go) begin
                rd_x     <= mem[rbank][rd_idx];
                rd_shift <= pos_shift(rd_idx);
                rcnt     <= rcnt + 4'd1;
                if (rcnt == 4'd15) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                    state       <= full[~rbank] ? RUN : IDLE;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

    // Magnitude needs 11 bits so that -512 becomes +512 rather than wrapping.
    logic [10:0]       mag;
    logic [11:0]       sum;
    logic [11:0]       q;
    logic signed [7:0] level;

    always_comb begin
        mag   = rd_x[9] ? (11'd0 - {rd_x[9], rd_x}) : {1'b0, rd_x};
        sum   = {1'b0, mag} + (12'd1 << (rd_shift - 3'd1));
        q     = sum >> rd_shift;
        level = '0;
        if (!rd_x[9])
            level = (q > 12'd127) ? 8'sd127 : q[7:0];
        else
            level = (q > 12'd128) ? -8'sd128 : (8'd0 - q[7:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
`ifdef ZZ_EOB_EN
            bus.out_last  <= 1'b0;
`endif
        end else begin
            bus.out_valid <= rd_valid;
            bus.out_data  <= rd_valid ? level : '0;
`ifdef ZZ_EOB_EN
            bus.out_last  <= rd_valid && rd_last;
`endif
        end
    end

endmodule

// File: doc/dct_zigzag_quant.md
Name: dct_zigzag_quant

Overview:
- Downstream consumer of the DCT stage's coefficient stream.
- Each block is 16 signed 10-bit coefficients of a 4x4 tile, arriving in raster (row-major) order.
- Buffers each block in a ping-pong store, quantizes per position with a rounded arithmetic shift, and emits 8-bit saturated levels in zigzag order.
- Feeds the entropy-coding stage.

Parameters:
- BASE_SHIFT, 2, base quantizer shift; legal range 1..4. Position (r,c) uses shift s = BASE_SHIFT + ((r+c)>>1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid coefficient this cycle.
- in_data  input  10  signed two's-complement DCT coefficient, raster order k = 4r+c.
- out_valid  output  1  out_data holds a valid quantized level.
- out_data  output  8  signed two's-complement quantized level, zigzag order.

Behaviour:
- Reset: the `rst` port is a synchronous, active-high reset; one clock, `clk`, and all logic updates on its rising edge.
  - While rst is sampled high: out_valid=0, out_data=0, write/read counters=0, both banks marked empty, read FSM=IDLE.
  - Reset mid-block discards any partial input block and any block being output.
  - out_valid is 0 on the cycle after rst is sampled high.
- Input side:
  - Each in_valid=1 cycle writes in_data into the current write bank at index wcnt; wcnt increments.
  - in_valid=0 cycles within a block are allowed and pause wcnt.
  - On the 16th write (wcnt=15), the bank is marked full, the write bank toggles and wcnt wraps to 0.
  - The write bank is always empty when written. With two banks, block length 16 and output rate 1/cycle, overflow is impossible; the bench checks for it anyway.
- Read FSM states: IDLE, RUN.
  - IDLE -> RUN when the read bank is full.
  - RUN: rcnt runs 0..15, one per cycle, reading raster index ZZ[rcnt] with ZZ = 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
  - At rcnt=15: the bank is marked empty and the read bank toggles. If the new read bank is already full, stay in RUN with rcnt=0 (no bubble); else go to IDLE.
- Latency: if the 16th coefficient is sampled at cycle T, the first out_valid is at T+2 (one cycle for the read, one for the quantizer register).
  - Output then runs 16 consecutive cycles, T+2..T+17.
  - Back-to-back input blocks give continuous out_valid.
- Quantization, for coefficient x at (r,c) with shift s:
  - q = (|x| + 2^(s-1)) >> s, i.e. round half away from zero.
  - Result = sign(x) ? -q : q.
  - Saturate to the range -128..127.
  - |x| is formed at 11 bits so that -512 is handled correctly.
- Simultaneous events:
  - A write to one bank and a read from the other in the same cycle are independent.
  - A bank's full-set (write side) and empty-clear (read side) never target the same bank in the same cycle.

Optional Feature:
- Macro ZZ_EOB_EN.
- Defined:
  - Adds output port out_last (1 bit), reset 0.
  - out_last is high together with out_valid on the 16th output of each block, and 0 otherwise.
- Undefined:
  - The port is absent and there is no related logic.

Test Plan:
- Ramp block: in_data = 4k for k = 0..15, contiguous.
  - Expect out_valid at T+2 for 16 cycles.
  - Expect out_data = 0,1,4,4,3,1,2,3,5,6,3,3,2,3,4,2.
- Saturation:
  - All coefficients 511 -> first output 127 (128 clamped).
  - All coefficients -512 -> first output -128.
  - Remaining outputs checked against the formula.
- Negative rounding at k=0: x=-6 -> -2; x=-5 -> -1; x=-2 -> -1; x=-1 -> 0.
- Back-to-back: three blocks with in_valid continuously high for 48 cycles.
  - Expect out_valid continuously high for 48 cycles starting at T1+2.
  - Expect no bubble and correct per-block data.
- Gapped input: in_valid toggling 1,0 across one block.
  - Output identical to the contiguous ramp case.
  - Output starts 2 cycles after the last valid input.
- Reset mid-operation:
  - Assert rst for 1 cycle after 9 inputs -> out_valid stays 0.
  - A following full ramp block produces the exact ramp sequence.
  - With ZZ_EOB_EN defined, out_last is high only on the 16th output.
